// File: rtl/knn_pkg.sv
// Shared KNN definitions: widths, reader FSM state encoding and k clamping.
package knn_pkg;

  localparam int KNN_W     = 32;
  localparam int KNN_IDX_W = KNN_W / 2;
  localparam int KNN_SEL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FIN
  } knn_rd_state_e;

  function automatic logic [KNN_SEL_W-1:0] knn_clamp_k(
    input logic [KNN_SEL_W-1:0] k,
    input logic [KNN_SEL_W-1:0] kmax
  );
    return (k > kmax) ? kmax : k;
  endfunction

endpackage

// File: rtl/knn_fifo2.sv
// Two-entry FIFO carrying a neighbour index plus its end-of-readout tag.
module knn_fifo2 #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output logic [1:0]    count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q  [2];
  logic          last_q [2];
  logic          wr_q, rd_q;
  logic [1:0]    count_q;
  logic          do_push, do_pop;

  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'd2);
  assign count     = count_q;
  assign head_data = mem_q[rd_q];
  assign head_last = last_q[rd_q];

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      count_q   <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q]  <= push_data;
        last_q[wr_q] <= push_last;
        wr_q         <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/knn_result_reader.sv
// Walks the sorter SEL index 0..k-1 and streams the returned neighbour
// indices over valid/ready, using a 2-entry buffer and issue credits.
module knn_result_reader
  import knn_pkg::*;
#(
  parameter int W    = 32,
  parameter int HW_K = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KNN_SEL_W-1:0] k_cfg,
  output logic [KNN_SEL_W-1:0] sel,
  input  logic [W/2-1:0]       idx_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W/2-1:0]       out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = W / 2;

  knn_rd_state_e        state_q;
  logic [KNN_SEL_W-1:0] keff_q, iss_q, sel_q;
  logic                 inflight_q, inflight_last_q;
  logic                 busy_q, done_q;

  logic [KNN_SEL_W-1:0] keff_start;
  logic [IW-1:0]        fifo_data;
  logic                 fifo_last, fifo_full, fifo_empty;
  logic [1:0]           fifo_count;
  logic [2:0]           occupancy;
  logic                 pop, credit_ok, issue, issue_is_last;

  assign keff_start = knn_clamp_k(k_cfg, KNN_SEL_W'(HW_K));

  assign pop = ~fifo_empty & out_ready;

  // Credits count the slot freed by this cycle's transfer, so a stalled
  // stream resumes issuing in the same cycle ready returns.
  assign occupancy     = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign credit_ok     = fifo_full ? pop : (occupancy < (3'd2 + {2'b00, pop}));
  assign issue         = (state_q == ST_ISSUE) && credit_ok;
  assign issue_is_last = (iss_q == keff_q - 16'd1);

  knn_fifo2 #(.DW(IW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (idx_in),
    .push_last (inflight_last_q),
    .pop       (pop),
    .head_data (fifo_data),
    .head_last (fifo_last),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      keff_q          <= '0;
      iss_q           <= '0;
      sel_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_is_last;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            keff_q <= keff_start;
            iss_q  <= '0;
            if (keff_start == '0) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ISSUE;
              sel_q   <= '0;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            sel_q <= iss_q;
            iss_q <= iss_q + 16'd1;
            if (issue_is_last) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && fifo_last) begin
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_FIN: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel       = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_data;
  assign out_last  = ~fifo_empty & fifo_last;

endmodule

// File: tb/tb_knn_result_reader.sv
// Directed bench for knn_result_reader with a combinational sorter slot model.
module tb_knn_result_reader;

  localparam int W    = 32;
  localparam int HW_K = 10;
  localparam int IW   = W / 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   k_cfg = '0;
  logic [15:0]   sel;
  logic [IW-1:0] idx_in;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [IW-1:0] slots [16];

  int n_checks = 0;
  int n_fail   = 0;

  knn_result_reader #(.W(W), .HW_K(HW_K)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_cfg     (k_cfg),
    .sel       (sel),
    .idx_in    (idx_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  assign idx_in = slots[sel[3:0]];

  always #5 clk = ~clk;

  task automatic pulse_start(input logic [15:0] k);
    @(negedge clk);
    k_cfg = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (sel !== 16'd0)    begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== '0)  begin n_fail++; $display("FAIL reset_data got=%0d exp=0", out_data); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", out_last); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0;
  endtask

  task automatic test_basic_k3;
    out_ready = 1'b1;
    pulse_start(16'd3);
    n_checks++; if (sel !== 16'd0)      begin n_fail++; $display("FAIL k3_c1_sel got=%0d exp=0", sel); end
    n_checks++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL k3_c1_busy got=%b exp=1", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL k3_c1_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL k3_c2_valid got=%b exp=0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL k3_valid[%0d] got=%b exp=1", i, out_valid); end
      n_checks++; if (out_data !== slots[i]) begin n_fail++; $display("FAIL k3_data[%0d] got=%0d exp=%0d", i, out_data, slots[i]); end
      n_checks++; if (out_last !== (i == 2)) begin n_fail++; $display("FAIL k3_last[%0d] got=%b exp=%b", i, out_last, (i == 2)); end
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1)      begin n_fail++; $display("FAIL k3_c6_done got=%b exp=1", done); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL k3_c6_busy got=%b exp=0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL k3_c6_valid got=%b exp=0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_k_clamp;
    int n;
    bit got_done;
    n = 0;
    got_done = 1'b0;
    out_ready = 1'b1;
    pulse_start(16'd25);
    n_checks++; if (sel !== 16'd0) begin n_fail++; $display("FAIL clamp_c1_sel got=%0d exp=0", sel); end
    for (int c = 0; c < 40 && !got_done; c++) begin
      if (out_valid && out_ready) begin
        n_checks++; if (out_data !== slots[n]) begin n_fail++; $display("FAIL clamp_data[%0d] got=%0d exp=%0d", n, out_data, slots[n]); end
        n_checks++; if (out_last !== (n == 9)) begin n_fail++; $display("FAIL clamp_last[%0d] got=%b exp=%b", n, out_last, (n == 9)); end
        n++;
      end
      if (done) got_done = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (!got_done)    begin n_fail++; $display("FAIL clamp_timeout done=%b exp=1", done); end
    n_checks++; if (n != 10)      begin n_fail++; $display("FAIL clamp_count got=%0d exp=10", n); end
    n_checks++; if (sel !== 16'd9) begin n_fail++; $display("FAIL clamp_sel got=%0d exp=9", sel); end
    @(negedge clk);
  endtask

  task automatic test_k_zero;
    pulse_start(16'd0);
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL k0_c1_busy got=%b exp=0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL k0_c1_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1)      begin n_fail++; $display("FAIL k0_c2_done got=%b exp=1", done); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL k0_c2_busy got=%b exp=0", busy); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL k0_c3_valid got=%b exp=0", out_valid); end
    n_checks++; if (sel !== 16'd9)      begin n_fail++; $display("FAIL k0_sel_hold got=%0d exp=9", sel); end
  endtask

  task automatic test_stall;
    int pat [6];
    int n;
    int outstanding;
    bit got_done;
    logic          prev_valid, prev_ready, prev_last;
    logic [IW-1:0] prev_data;
    pat = '{1, 0, 0, 1, 0, 1};
    n = 0;
    got_done = 1'b0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_last  = 1'b0;
    prev_data  = '0;
    pulse_start(16'd5);
    for (int c = 0; c < 60 && !got_done; c++) begin
      if (prev_valid && !prev_ready) begin
        n_checks++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL stall_valid_drop got=%b exp=1", out_valid); end
        n_checks++; if (out_data !== prev_data) begin n_fail++; $display("FAIL stall_data got=%0d exp=%0d", out_data, prev_data); end
        n_checks++; if (out_last !== prev_last) begin n_fail++; $display("FAIL stall_last got=%b exp=%b", out_last, prev_last); end
      end
      if (busy) begin
        outstanding = int'(sel) + 1 - n;
        n_checks++; if (outstanding > 2) begin n_fail++; $display("FAIL stall_credit got=%0d exp<=2", outstanding); end
      end
      out_ready = pat[c % 6][0];
      if (out_valid && out_ready) begin
        n_checks++; if (out_data !== slots[n]) begin n_fail++; $display("FAIL stall_xfer[%0d] got=%0d exp=%0d", n, out_data, slots[n]); end
        n_checks++; if (out_last !== (n == 4)) begin n_fail++; $display("FAIL stall_xlast[%0d] got=%b exp=%b", n, out_last, (n == 4)); end
        n++;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) got_done = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (!got_done) begin n_fail++; $display("FAIL stall_timeout done=%b exp=1", done); end
    n_checks++; if (n != 5)    begin n_fail++; $display("FAIL stall_count got=%0d exp=5", n); end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_restart_ignored;
    int n;
    bit got_done;
    n = 0;
    got_done = 1'b0;
    out_ready = 1'b1;
    pulse_start(16'd4);
    @(negedge clk);
    k_cfg = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got=%b exp=1", busy); end
    for (int c = 0; c < 30 && !got_done; c++) begin
      if (out_valid && out_ready) begin
        n_checks++; if (out_data !== slots[n]) begin n_fail++; $display("FAIL restart_data[%0d] got=%0d exp=%0d", n, out_data, slots[n]); end
        n_checks++; if (out_last !== (n == 3)) begin n_fail++; $display("FAIL restart_last[%0d] got=%b exp=%b", n, out_last, (n == 3)); end
        n++;
      end
      if (done) got_done = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (!got_done) begin n_fail++; $display("FAIL restart_timeout done=%b exp=1", done); end
    n_checks++; if (n != 4)    begin n_fail++; $display("FAIL restart_count got=%0d exp=4", n); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL idle_done got=%b exp=1", done); end
    pulse_start(16'd1);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_clear got=%b exp=0", done); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL done_clear_busy got=%b exp=1", busy); end
    n = 0;
    got_done = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      if (out_valid && out_ready) begin
        n_checks++; if (out_data !== slots[0] || out_last !== 1'b1) begin
          n_fail++; $display("FAIL k1_xfer got=%0d/%b exp=%0d/1", out_data, out_last, slots[0]);
        end
        n++;
      end
      if (done) got_done = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (!got_done || n != 1) begin n_fail++; $display("FAIL k1_count got=%0d done=%b exp=1/1", n, got_done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    pulse_start(16'd5);
    repeat (4) @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    n_checks++; if (sel !== 16'd1)      begin n_fail++; $display("FAIL mid_pre_sel got=%0d exp=1", sel); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (sel !== 16'd0)      begin n_fail++; $display("FAIL mid_sel got=%0d exp=0", sel); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL mid_data got=%0d exp=0", out_data); end
    n_checks++; if (out_last !== 1'b0)  begin n_fail++; $display("FAIL mid_last got=%b exp=0", out_last); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL mid_done got=%b exp=0", done); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL post_reset[%0d] valid=%b busy=%b exp=0/0", c, out_valid, busy);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) slots[i] = 16'(1000 + i);
    slots[0] = 16'd7;
    slots[1] = 16'd3;
    slots[2] = 16'd9;
    slots[3] = 16'd12;
    slots[4] = 16'd5;
    slots[5] = 16'd100;
    slots[6] = 16'd42;
    slots[7] = 16'd8;
    slots[8] = 16'd1;
    slots[9] = 16'hBEEF;

    test_reset();
    test_basic_k3();
    test_k_clamp();
    test_k_zero();
    test_stall();
    test_restart_ignored();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
